tx_eight_ten_ctrl: RTL and testbench
====================================

// Module: tx_eight_ten_ctrl
// PURPOSE
//  Sequencer for the 10-bit UART transmit datapath (tx_eight_ten_dp). Accepts a 10-bit word on a
//  start/ready handshake and captures it. Generates the baud-rate bit timing. Drives tx_en and
//  bit_cnto so the datapath emits start bit, tx_d[0..9] LSB first, then stop bit: 12 bit periods.
//  Sits between the host/bus-side TX logic and the datapath; the datapath's rst is tied to ~rst_n.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per bit period (50 MHz / 115200); legal range >= 2
//  GUARD_BITS    0    extra idle (line-high) bit periods inserted after every stop bit; 0..15
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  tx_start  in   1   request to send; sampled only while tx_ready=1
//  tx_data   in   10  word to send; captured in the cycle tx_start is accepted
//  tx_ready  out  1   1 = controller idle, tx_start will be accepted this cycle
//  tx_busy   out  1   1 = frame or guard period in progress
//  tx_done   out  1   single-cycle pulse at end of stop bit
//  tx_en     out  1   datapath enable; 1 exactly during the 12 frame bit periods
//  bit_cnto  out  10  datapath bit index: 0=start, 1..10=tx_d[0..9], 11=stop
//  tx_d      out  10  captured word to datapath, stable for the whole frame
// BEHAVIOUR
//  Reset (rst_n=0, immediate, async): state=IDLE, tx_ready=1, tx_busy=0, tx_done=0, tx_en=0,
//   bit_cnto=0, tx_d=0, baud counter=0. A reset mid-frame aborts it; the line returns high via tx_en=0.
//  Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 in SEND/GUARD, held at 0 in IDLE.
//   bit_tick = (count == CLKS_PER_BIT-1); the counter wraps to 0 on bit_tick.
//  States: IDLE, SEND, GUARD (encoded 2 bits; unused code -> IDLE).
//  IDLE: tx_ready=1. If tx_start=1: tx_d<=tx_data, tx_en<=1, bit_cnto<=0, tx_busy<=1, tx_ready<=0,
//   state<=SEND. Accepted word therefore appears on the line one clock after the accept cycle.
//  SEND: on bit_tick with bit_cnto<11: bit_cnto<=bit_cnto+1.
//   On bit_tick with bit_cnto==11: tx_en<=0, bit_cnto<=0, tx_done<=1 for one cycle.
//   If GUARD_BITS==0 -> IDLE (tx_busy<=0, tx_ready<=1). Otherwise -> GUARD.
//   Each bit period is exactly CLKS_PER_BIT clocks; the frame is exactly 12*CLKS_PER_BIT clocks.
//  GUARD: tx_en=0, line idle. Guard-bit counter counts bit_ticks; after GUARD_BITS ticks -> IDLE.
//  tx_start is ignored while tx_ready=0. No queuing: a request pulse during busy is lost.
//  tx_data changes after accept have no effect on tx_d until the next accept.
//  tx_start held high continuously gives back-to-back frames:
//   tx_done cycle -> IDLE -> accept on next clock -> 1-clock idle gap (+ GUARD_BITS periods).
//  tx_done and tx_ready never assert in the same cycle; tx_ready rises the cycle after tx_done.
//  bit_cnto never exceeds 11; tx_en=1 implies bit_cnto in 0..11.
// TESTING (CLKS_PER_BIT=4, GUARD_BITS=0 unless stated; datapath instantiated, line = tx_out)
//  1 Reset: rst_n=0 mid-clock -> same instant tx_en=0, bit_cnto=0, tx_ready=1, tx_busy=0, tx_out=1.
//  2 Single frame: tx_data=10'h2A5, tx_start pulse at cycle T -> tx_en=1 from T+1.
//    bit_cnto steps 0..11 every 4 clocks; line = 0,1,0,1,0,0,1,0,1,0,1,1.
//    tx_done=1 at T+48 only; tx_ready=1 from T+49.
//  3 Ignore while busy: second tx_start with tx_data=10'h3FF at bit 4 -> no effect.
//    tx_d stays 10'h2A5, single tx_done, frame length unchanged (48 clocks).
//  4 Back-to-back: tx_start held high, data 10'h001 then 10'h200 -> second frame tx_en rises
//    2 clocks after first tx_done. Repeat with GUARD_BITS=2 -> gap = 2+8 clocks.
//  5 Reset mid-frame: rst_n low at bit_cnto=5 for 3 clocks -> outputs at reset values, no tx_done.
//    After release, start 10'h155 -> full correct frame.
//  6 Minimum divider: CLKS_PER_BIT=2, tx_data=10'h0F0 -> 24-clock frame, bit periods exactly 2 clocks.

Source files
------------

// File: rtl/tx_eight_ten_ctrl.sv
// Sequencer for the 10-bit UART transmit datapath: captures a word on start/ready,
// times the 12 frame bit periods and any idle guard periods that follow the stop bit.
//
//   state | meaning
//   IDLE  | line idle, tx_ready=1, waiting for tx_start
//   SEND  | frame on the line, bit_cnto walks 0 (start) .. 11 (stop)
//   GUARD | extra line-high bit periods after the stop bit
module tx_eight_ten_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GUARD_BITS   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [9:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_en,
    output logic [9:0] bit_cnto,
    output logic [9:0] tx_d
);

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_PRE    = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]      GUARD_LAST = 4'((GUARD_BITS > 0) ? (GUARD_BITS - 1) : 0);
    localparam logic [9:0]      STOP_IDX   = 10'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    guard_cnt;
    logic          bit_tick;
    logic          pre_tick;

    assign bit_tick = (baud_cnt == CNT_LAST);
    assign pre_tick = (baud_cnt == CNT_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            guard_cnt <= '0;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_en     <= 1'b0;
            bit_cnto  <= '0;
            tx_d      <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt  <= '0;
                    guard_cnt <= '0;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    tx_en     <= 1'b0;
                    bit_cnto  <= '0;
                    if (tx_start) begin
                        tx_d     <= tx_data;
                        tx_en    <= 1'b1;
                        tx_busy  <= 1'b1;
                        tx_ready <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
                    // Raise tx_done one clock early so it lands in the last stop-bit cycle,
                    // one cycle before tx_ready returns.
                    if (pre_tick && bit_cnto == STOP_IDX) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (bit_cnto != STOP_IDX) begin
                            bit_cnto <= bit_cnto + 10'd1;
                        end else begin
                            tx_en     <= 1'b0;
                            bit_cnto  <= '0;
                            guard_cnt <= '0;
                            if (GUARD_BITS == 0) begin
                                tx_busy  <= 1'b0;
                                tx_ready <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                state <= GUARD;
                            end
                        end
                    end
                end
                GUARD: begin
                    baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
                    tx_en    <= 1'b0;
                    if (bit_tick) begin
                        if (guard_cnt == GUARD_LAST) begin
                            guard_cnt <= '0;
                            tx_busy   <= 1'b0;
                            tx_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            guard_cnt <= guard_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    baud_cnt  <= '0;
                    guard_cnt <= '0;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    tx_en     <= 1'b0;
                    bit_cnto  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_eight_ten_ctrl.sv
// Directed bench for tx_eight_ten_ctrl: three instances cover the default divider,
// a guard-bit build and the minimum divider; the line is reconstructed from tx_en/bit_cnto/tx_d.
module tb_tx_eight_ten_ctrl;

    logic            clk;
    logic            rst_n;
    logic [2:0]      start_v;
    logic [9:0]      data_v;
    logic [2:0]      ready_v, busy_v, done_v, en_v;
    logic [2:0][9:0] cnt_v, d_v;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tx_eight_ten_ctrl #(.CLKS_PER_BIT(4), .GUARD_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_start(start_v[0]), .tx_data(data_v),
        .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx_en(en_v[0]),
        .bit_cnto(cnt_v[0]), .tx_d(d_v[0]));

    tx_eight_ten_ctrl #(.CLKS_PER_BIT(4), .GUARD_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_start(start_v[1]), .tx_data(data_v),
        .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx_en(en_v[1]),
        .bit_cnto(cnt_v[1]), .tx_d(d_v[1]));

    tx_eight_ten_ctrl #(.CLKS_PER_BIT(2), .GUARD_BITS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_start(start_v[2]), .tx_data(data_v),
        .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx_en(en_v[2]),
        .bit_cnto(cnt_v[2]), .tx_d(d_v[2]));

    // What the datapath would put on the line for these controller outputs.
    function automatic logic dp_line(input logic en, input logic [9:0] c, input logic [9:0] d);
        if (!en) return 1'b1;
        if (c == 10'd0) return 1'b0;
        if (c >= 10'd11) return 1'b1;
        return d[c - 10'd1];
    endfunction

    task automatic check_reset_vals(input int u, input string tag);
        logic [24:0] act, exp;
        exp = {1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
        act = {en_v[u], cnt_v[u], dp_line(en_v[u], cnt_v[u], d_v[u]), done_v[u],
               ready_v[u], busy_v[u], d_v[u]};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input int u, input logic exp_ready, input logic exp_busy,
                              input string tag);
        logic [14:0] act, exp;
        exp = {1'b0, 10'd0, 1'b1, 1'b0, exp_ready, exp_busy};
        act = {en_v[u], cnt_v[u], dp_line(en_v[u], cnt_v[u], d_v[u]), done_v[u],
               ready_v[u], busy_v[u]};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Entered at the negedge of the first frame cycle; leaves at the first cycle after the frame.
    task automatic check_frame(input int u, input int cpb, input logic [9:0] data,
                               input logic [11:0] exp_line, input int poke_k, input string tag);
        logic [24:0] act, exp;
        int n, b;
        n = 12 * cpb;
        for (int k = 1; k <= n; k++) begin
            b = (k - 1) / cpb;
            exp = {1'b1, 10'(b), exp_line[b], (k == n), 1'b0, 1'b1, data};
            act = {en_v[u], cnt_v[u], dp_line(en_v[u], cnt_v[u], d_v[u]), done_v[u],
                   ready_v[u], busy_v[u], d_v[u]};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, k, act, exp);
            end
            if (poke_k != 0 && k == poke_k) begin
                data_v     = 10'h3FF;
                start_v[u] = 1'b1;
            end
            if (poke_k != 0 && k == poke_k + 1) start_v[u] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic start_pulse(input int u, input logic [9:0] data);
        data_v     = data;
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_v = 3'b000;
        data_v  = 10'h000;
        repeat (2) @(negedge clk);
        check_reset_vals(0, "reset_a");
        check_reset_vals(1, "reset_b");
        check_reset_vals(2, "reset_c");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals(0, "after_release");
        start_pulse(0, 10'h2A5);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals(0, "async_reset_midclock");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        start_pulse(0, 10'h2A5);
        check_frame(0, 4, 10'h2A5, 12'hD4A, 0, "single_frame");
        check_idle(0, 1'b1, 1'b0, "single_frame_ready");
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        start_pulse(0, 10'h2A5);
        check_frame(0, 4, 10'h2A5, 12'hD4A, 17, "ignore_busy");
        check_idle(0, 1'b1, 1'b0, "ignore_busy_end");
        @(negedge clk);
        check_idle(0, 1'b1, 1'b0, "ignore_busy_no_restart");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        data_v     = 10'h001;
        start_v[0] = 1'b1;
        @(negedge clk);
        data_v = 10'h200;
        check_frame(0, 4, 10'h001, 12'h802, 0, "b2b_first");
        check_idle(0, 1'b1, 1'b0, "b2b_gap");
        @(negedge clk);
        start_v[0] = 1'b0;
        check_frame(0, 4, 10'h200, 12'hC00, 0, "b2b_second");
        check_idle(0, 1'b1, 1'b0, "b2b_end");
        @(negedge clk);

        data_v     = 10'h001;
        start_v[1] = 1'b1;
        @(negedge clk);
        data_v = 10'h200;
        check_frame(1, 4, 10'h001, 12'h802, 0, "guard_first");
        for (int i = 0; i < 8; i++) begin
            check_idle(1, 1'b0, 1'b1, "guard_period");
            @(negedge clk);
        end
        check_idle(1, 1'b1, 1'b0, "guard_ready");
        @(negedge clk);
        start_v[1] = 1'b0;
        check_frame(1, 4, 10'h200, 12'hC00, 0, "guard_second");
        repeat (8) @(negedge clk);
        check_idle(1, 1'b1, 1'b0, "guard_end");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        start_pulse(0, 10'h2A5);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (cnt_v[0] !== 10'd5) begin
            n_bad++;
            $display("FAIL midframe_position: got %0d expected 5", cnt_v[0]);
        end
        #1 rst_n = 1'b0;
        #1 check_reset_vals(0, "midframe_reset_now");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals(0, "midframe_reset_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, 1'b1, 1'b0, "midframe_after_release");
        start_pulse(0, 10'h155);
        check_frame(0, 4, 10'h155, 12'hAAA, 0, "post_reset_frame");
        check_idle(0, 1'b1, 1'b0, "post_reset_end");
        @(negedge clk);
    endtask

    task automatic test_min_divider();
        start_pulse(2, 10'h0F0);
        check_frame(2, 2, 10'h0F0, 12'h9E0, 0, "min_divider");
        check_idle(2, 1'b1, 1'b0, "min_divider_end");
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_divider();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
